// File: rtl/sound_arbiter.sv
// Purpose : shares one piezo tone driver between alarm, keypad click and lullaby (priority in that order),
//           inserting a silent guard gap whenever ownership changes.
// Latency : grant/owner follow a request one cycle later; play_sound carries the beat two cycles after it is presented.
// Backpressure: none; requests are levels and are re-arbitrated every cycle. A click is held pending until it can be played.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   alarm_req/_beat     alarm generator request level and 13-bit tone code
//   lull_req/_beat      lullaby generator request level and 13-bit tone code
//   key_pulse           single-cycle keypad strobe (requests a click)
//   mute                forces play_sound to 0 without stopping arbitration
//   play_sound          tone code to the piezo, 0 = silent
//   alarm_grant         alarm owns the piezo
//   lull_grant          lullaby owns the piezo
//   owner               0 none/gap, 1 alarm, 2 click, 3 lullaby
//   busy                arbiter is not idle
// Build option: define SOUND_ARB_CLICK_EN to include the keypad click path; without it key_pulse is ignored.
module sound_arbiter #(
    parameter int          GAP_CYCLES   = 2000,
    parameter int          CLICK_CYCLES = 50000,
    parameter logic [12:0] CLICK_NOTE   = 13'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alarm_req,
    input  logic [12:0] alarm_beat,
    input  logic        lull_req,
    input  logic [12:0] lull_beat,
    input  logic        key_pulse,
    input  logic        mute,
    output logic [12:0] play_sound,
    output logic        alarm_grant,
    output logic        lull_grant,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam int MAX_CYC = (GAP_CYCLES > CLICK_CYCLES) ? GAP_CYCLES : CLICK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counter is loaded with N-1 on entry so the state lasts exactly N cycles
    // and the exit decision is taken in the cycle where it reads zero.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`ifdef SOUND_ARB_CLICK_EN
    localparam logic [CNT_W-1:0] CLICK_LOAD = CNT_W'(CLICK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ALARM,
`ifdef SOUND_ARB_CLICK_EN
        S_CLICK,
`endif
        S_LULL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    state_t             sel;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               click_eff;
    logic [12:0]        alarm_beat_d;
    logic [12:0]        lull_beat_d;
    logic [12:0]        play_nxt;
    logic [1:0]         owner_nxt;

`ifdef SOUND_ARB_CLICK_EN
    logic               click_pending;
    logic               click_pending_nxt;
`else
    logic               unused_click;
    assign unused_click = key_pulse ^ (^CLICK_NOTE);
`endif

    always_comb begin
        // A keypress is visible to arbitration in the same cycle it arrives,
        // so a click requested together with the lullaby from idle goes first.
        click_eff = 1'b0;
`ifdef SOUND_ARB_CLICK_EN
        click_eff = click_pending | (key_pulse & ~alarm_req & (state != S_ALARM));
`endif

        if (alarm_req) begin
            sel = S_ALARM;
        end
`ifdef SOUND_ARB_CLICK_EN
        else if (click_eff) begin
            sel = S_CLICK;
        end
`endif
        else if (lull_req) begin
            sel = S_LULL;
        end else begin
            sel = S_IDLE;
        end

        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = sel;
            S_ALARM: if (!alarm_req) state_nxt = S_GAP;
            S_LULL:  if (!lull_req || alarm_req || click_eff) state_nxt = S_GAP;
`ifdef SOUND_ARB_CLICK_EN
            S_CLICK: if (alarm_req || (cnt == '0)) state_nxt = S_GAP;
`endif
            // sel is taken at expiry, so requests that vanished during the gap are not granted.
            S_GAP:   if (cnt == '0) state_nxt = sel;
            default: state_nxt = S_IDLE;
        endcase

        cnt_nxt = cnt;
        if (state_nxt != state) begin
            case (state_nxt)
                S_GAP:   cnt_nxt = GAP_LOAD;
`ifdef SOUND_ARB_CLICK_EN
                S_CLICK: cnt_nxt = CLICK_LOAD;
`endif
                default: cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

`ifdef SOUND_ARB_CLICK_EN
        click_pending_nxt = ((state_nxt == S_CLICK) && (state != S_CLICK)) ? 1'b0 : click_eff;
`endif

        owner_nxt = 2'd0;
        play_nxt  = 13'd0;
        case (state_nxt)
            S_ALARM: begin
                owner_nxt = 2'd1;
                play_nxt  = alarm_beat_d;
            end
`ifdef SOUND_ARB_CLICK_EN
            S_CLICK: begin
                owner_nxt = 2'd2;
                play_nxt  = CLICK_NOTE;
            end
`endif
            S_LULL: begin
                owner_nxt = 2'd3;
                play_nxt  = lull_beat_d;
            end
            default: begin
                owner_nxt = 2'd0;
                play_nxt  = 13'd0;
            end
        endcase
        if (mute) play_nxt = 13'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            alarm_beat_d  <= 13'd0;
            lull_beat_d   <= 13'd0;
            play_sound    <= 13'd0;
            alarm_grant   <= 1'b0;
            lull_grant    <= 1'b0;
            owner         <= 2'd0;
            busy          <= 1'b0;
`ifdef SOUND_ARB_CLICK_EN
            click_pending <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            alarm_beat_d  <= alarm_beat;
            lull_beat_d   <= lull_beat;
            play_sound    <= play_nxt;
            alarm_grant   <= (state_nxt == S_ALARM);
            lull_grant    <= (state_nxt == S_LULL);
            owner         <= owner_nxt;
            busy          <= (state_nxt != S_IDLE);
`ifdef SOUND_ARB_CLICK_EN
            click_pending <= click_pending_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sound_arbiter.sv
// Purpose : directed plus randomized checking of sound_arbiter against a timestamp-based reference model.
// Latency : outputs compared 1 time unit after every rising clock edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_sound_arbiter;

    localparam int          GAP  = 4;
    localparam int          CLK  = 10;
    localparam logic [12:0] NOTE = 13'd1;
`ifdef SOUND_ARB_CLICK_EN
    localparam bit CLICK_EN = 1'b1;
`else
    localparam bit CLICK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        alarm_req;
    logic [12:0] alarm_beat;
    logic        lull_req;
    logic [12:0] lull_beat;
    logic        key_pulse;
    logic        mute;
    logic [12:0] play_sound;
    logic        alarm_grant;
    logic        lull_grant;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sound_arbiter #(
        .GAP_CYCLES   (GAP),
        .CLICK_CYCLES (CLK),
        .CLICK_NOTE   (NOTE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alarm_req   (alarm_req),
        .alarm_beat  (alarm_beat),
        .lull_req    (lull_req),
        .lull_beat   (lull_beat),
        .key_pulse   (key_pulse),
        .mute        (mute),
        .play_sound  (play_sound),
        .alarm_grant (alarm_grant),
        .lull_grant  (lull_grant),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: who owns the piezo (0 nobody, 1 alarm, 2 click, 3 lullaby),
    // whether a guard gap is running, and the last cycle of the running gap/click.
    int          r_own;
    bit          r_gap;
    int          r_until;
    bit          r_pend;
    logic [12:0] r_abd, r_lbd;
    logic [12:0] e_play;
    logic        e_ag, e_lg, e_busy;
    logic [1:0]  e_owner;

    task automatic model_edge();
        int  want;
        int  n_own;
        bit  n_gap;
        bit  pend_now;
        if (reset) begin
            r_own = 0; r_gap = 0; r_until = 0; r_pend = 0;
            r_abd = 0; r_lbd = 0;
            e_play = 0; e_ag = 0; e_lg = 0; e_busy = 0; e_owner = 0;
            return;
        end
        pend_now = CLICK_EN && (r_pend || (key_pulse && !alarm_req && !(r_own == 1 && !r_gap)));
        want = alarm_req ? 1 : pend_now ? 2 : lull_req ? 3 : 0;
        n_own = r_own;
        n_gap = r_gap;
        if (r_gap) begin
            if (cyc == r_until) begin
                n_gap = 0;
                n_own = want;
                if (want == 2) r_until = cyc + CLK;
            end
        end else if (r_own == 0) begin
            n_own = want;
            if (want == 2) r_until = cyc + CLK;
        end else begin
            if ((r_own == 1 && !alarm_req) ||
                (r_own == 3 && (!lull_req || alarm_req || pend_now)) ||
                (r_own == 2 && (alarm_req || cyc == r_until))) begin
                n_gap = 1;
                n_own = 0;
                r_until = cyc + GAP;
            end
        end
        r_pend = (n_own == 2 && r_own != 2) ? 1'b0 : pend_now;
        e_owner = 2'(n_own);
        e_ag    = (n_own == 1);
        e_lg    = (n_own == 3);
        e_busy  = n_gap || (n_own != 0);
        e_play  = mute ? 13'd0 : (n_own == 1) ? r_abd : (n_own == 2) ? NOTE : (n_own == 3) ? r_lbd : 13'd0;
        r_abd = alarm_beat;
        r_lbd = lull_beat;
        r_own = n_own;
        r_gap = n_gap;
    endtask

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        cyc++;
        #1;
        chk("m_play",  play_sound, e_play);
        chk("m_ag",    13'(alarm_grant), 13'(e_ag));
        chk("m_lg",    13'(lull_grant),  13'(e_lg));
        chk("m_owner", 13'(owner),       13'(e_owner));
        chk("m_busy",  13'(busy),        13'(e_busy));
    endtask

    initial begin
        reset = 1; alarm_req = 0; alarm_beat = 0; lull_req = 0; lull_beat = 0;
        key_pulse = 0; mute = 0;
        step(); step();
        chk("rst_play", play_sound, 13'd0);
        chk("rst_busy", 13'(busy), 13'd0);
        reset = 0;
        repeat (8) step();

        // Alarm from idle
        alarm_req = 1; alarm_beat = 13'd262;
        step();
        chk("a_grant", 13'(alarm_grant), 13'd1);
        chk("a_owner", 13'(owner), 13'd1);
        chk("a_play_lag", play_sound, 13'd0);
        step();
        chk("a_play", play_sound, 13'd262);
        repeat (3) step();
        alarm_req = 0;
        step();
        chk("a_gap_owner", 13'(owner), 13'd0);
        repeat (GAP) step();
        chk("a_idle", 13'(busy), 13'd0);

        // Alarm preempts lullaby
        lull_req = 1; lull_beat = 13'd440;
        step();
        chk("l_grant", 13'(lull_grant), 13'd1);
        repeat (3) step();
        chk("l_play", play_sound, 13'd440);
        alarm_req = 1; alarm_beat = 13'd523;
        step();
        chk("p_lg_drop", 13'(lull_grant), 13'd0);
        chk("p_gap_play", play_sound, 13'd0);
        for (int i = 1; i < GAP; i++) begin
            step();
            chk("p_gap_play", play_sound, 13'd0);
            chk("p_gap_ag", 13'(alarm_grant), 13'd0);
        end
        step();
        chk("p_ag", 13'(alarm_grant), 13'd1);
        chk("p_play", play_sound, 13'd523);
        repeat (3) step();
        chk("p_lg_hold", 13'(lull_grant), 13'd0);

        // Mute during alarm
        mute = 1;
        step(); step();
        chk("mute_play", play_sound, 13'd0);
        chk("mute_ag", 13'(alarm_grant), 13'd1);
        mute = 0;
        step(); step();
        chk("unmute_play", play_sound, 13'd523);

        // Click suppressed under alarm
        key_pulse = 1;
        step();
        key_pulse = 0;
        step();
        alarm_req = 0; lull_req = 0;
        repeat (GAP + 1) step();
        chk("sup_busy", 13'(busy), 13'd0);
        chk("sup_owner", 13'(owner), 13'd0);

        // Click inserted into lullaby
        lull_req = 1; lull_beat = 13'd440;
        step(); step();
        key_pulse = 1;
        step();
        key_pulse = 0;
        chk("c_gap1", 13'(owner), CLICK_EN ? 13'd0 : 13'd3);
        for (int i = 1; i < GAP; i++) begin
            step();
            chk("c_gap1", play_sound, CLICK_EN ? 13'd0 : 13'd440);
        end
        for (int i = 0; i < CLK; i++) begin
            step();
            chk("c_click_owner", 13'(owner), CLICK_EN ? 13'd2 : 13'd3);
            chk("c_click_play", play_sound, CLICK_EN ? NOTE : 13'd440);
        end
        for (int i = 0; i < GAP; i++) begin
            step();
            chk("c_gap2", play_sound, CLICK_EN ? 13'd0 : 13'd440);
        end
        step();
        chk("c_resume", 13'(owner), 13'd3);
        chk("c_resume_play", play_sound, 13'd440);

        // Reset in the middle of a click
        key_pulse = 1;
        step();
        key_pulse = 0;
        repeat (GAP + 2) step();
        reset = 1;
        step();
        reset = 0;
        chk("r_play", play_sound, 13'd0);
        chk("r_owner", 13'(owner), 13'd0);
        chk("r_busy", 13'(busy), 13'd0);
        chk("r_lg", 13'(lull_grant), 13'd0);

        // Keypress from idle
        lull_req = 0;
        repeat (GAP + 3) step();
        key_pulse = 1;
        step();
        key_pulse = 0;
        chk("k_busy", 13'(busy), CLICK_EN ? 13'd1 : 13'd0);
        chk("k_play", play_sound, CLICK_EN ? NOTE : 13'd0);
        repeat (CLK + GAP + 2) step();
        chk("k_done", 13'(busy), 13'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) alarm_req = ~alarm_req;
            if ($urandom_range(0, 99) < 5) lull_req  = ~lull_req;
            if ($urandom_range(0, 99) < 2) mute      = ~mute;
            key_pulse  = ($urandom_range(0, 99) < 4);
            reset      = ($urandom_range(0, 999) < 5);
            alarm_beat = 13'($urandom);
            lull_beat  = 13'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single piezo tone driver between three sound sources: alarm melody, lullaby, and a keypad click.
- Priority order is alarm, then click, then lullaby.
- A silent guard gap is inserted whenever ownership changes, so tones never splice together.
- Sits between the lullaby/alarm beat generators and one piezo instance, replacing the OR of two piezo outputs.

Parameters:
- GAP_CYCLES, 2000: silent clock cycles inserted on every owner change (2 ms at 1 MHz).
- CLICK_CYCLES, 50000: click tone duration in clock cycles (50 ms at 1 MHz).
- CLICK_NOTE, 13'd1: tone code driven on play_sound during a click.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alarm_req  in  1  alarm generator wants the piezo (level)
- alarm_beat  in  13  alarm tone code
- lull_req  in  1  lullaby generator wants the piezo (level)
- lull_beat  in  13  lullaby tone code
- key_pulse  in  1  single-cycle keypad-press strobe
- mute  in  1  forces silence; arbitration continues
- play_sound  out  13  tone code to the piezo; 0 = silent
- alarm_grant  out  1  alarm currently owns the piezo
- lull_grant  out  1  lullaby currently owns the piezo
- owner  out  2  0 none/gap, 1 alarm, 2 click, 3 lullaby
- busy  out  1  state is not IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0, click_pending 0.
- States: IDLE, GAP, ALARM, CLICK, LULL. All outputs are registered from state.
- Arbitration function sel, evaluated each cycle:
  - ALARM if alarm_req;
  - else CLICK if click_pending;
  - else LULL if lull_req;
  - else NONE.
- click_pending:
  - set by key_pulse when alarm_req=0 and state is not ALARM;
  - cleared on entry to CLICK;
  - key_pulse while alarm_req=1 or state=ALARM is discarded.
- IDLE:
  - sel≠NONE: go directly to the selected state next cycle, with no gap.
  - Example: alarm_req rises at cycle N → alarm_grant=1 and owner=1 at N+1.
- ALARM: leave when alarm_req=0 → GAP.
- LULL:
  - leave to GAP when lull_req=0, alarm_req=1, or click_pending=1.
  - The lullaby is preempted, not cancelled: if lull_req is still high after the click, it resumes via GAP.
- CLICK:
  - lasts exactly CLICK_CYCLES cycles, then → GAP.
  - alarm_req=1 during CLICK aborts it immediately → GAP.
- GAP:
  - play_sound=0, owner=0, all grants 0, for exactly GAP_CYCLES cycles.
  - At expiry: sel≠NONE → selected state; otherwise → IDLE.
  - sel is re-evaluated at expiry, not at gap entry.
- play_sound:
  - ALARM: alarm_beat delayed one cycle.
  - LULL: lull_beat delayed one cycle.
  - CLICK: CLICK_NOTE.
  - IDLE/GAP, or mute=1: 0.
- Counters:
  - a single down-counter, width ceil(log2(max(GAP_CYCLES, CLICK_CYCLES)+1));
  - loaded on state entry; does not wrap.
- Simultaneous alarm_req rise and key_pulse in IDLE: ALARM wins and the click is discarded.
- Simultaneous lull_req and key_pulse in IDLE: CLICK first, then GAP, then LULL.
- Requests dropping while their grant is pending in GAP: re-evaluated at gap expiry; no stale grant is issued.
- reset asserted mid-operation: next cycle all outputs are 0 and state is IDLE; click_pending is cleared.

Optional Feature:
- Macro SOUND_ARB_CLICK_EN.
- Defined: click path present as described.
- Undefined:
  - CLICK state and click_pending are removed;
  - key_pulse is ignored;
  - owner never equals 2;
  - CLICK_NOTE and CLICK_CYCLES are unused.

Test Plan:
- Alarm from idle:
  - stimulus: reset, then alarm_req=1 with alarm_beat=13'd262 at cycle 10;
  - required: alarm_grant=1 and owner=1 at cycle 11; play_sound=262 from cycle 12.
- Alarm preempts lullaby:
  - stimulus: lull_req=1 with lull_beat=13'd440, then alarm_req=1;
  - required: lull_grant drops next cycle; play_sound=0 for exactly 2000 cycles; then alarm_grant=1; lull_grant stays 0 while alarm_req=1.
- Click inserted into lullaby (GAP_CYCLES=4, CLICK_CYCLES=10):
  - stimulus: key_pulse during LULL;
  - required sequence: 4 zero cycles, 10 cycles of CLICK_NOTE with owner=2, 4 zero cycles, then lullaby resumes with owner=3.
- Click suppressed under alarm:
  - stimulus: key_pulse during ALARM, then alarm_req drops;
  - required: GAP then IDLE; no click is played; busy=0 after the gap.
- Mute and mid-operation reset:
  - stimulus: mute=1 during ALARM;
  - required: play_sound=0 while alarm_grant stays 1.
  - stimulus: reset pulse during CLICK;
  - required: all outputs 0 next cycle.
- Macro undefined:
  - stimulus: key_pulse in IDLE;
  - required: busy stays 0 and play_sound stays 0.
